// File: rtl/uart_pkg.sv
// Shared constants, FSM state type and baud divisor helper for the oversampled UART receiver.
package uart_pkg;

   localparam int unsigned PARITY_NONE = 0;
   localparam int unsigned PARITY_ODD  = 1;
   localparam int unsigned PARITY_EVEN = 2;

   typedef enum logic [2:0] {
      StIdle,
      StStart,
      StData,
      StParity,
      StStop,
      StBreak
   } rx_state_e;

   // Rounded clocks per oversampling tick.
   function automatic int unsigned uart_divisor(input int unsigned clock_hz,
                                                input int unsigned baud,
                                                input int unsigned oversample);
      int unsigned den;
      den = baud * oversample;
      return (clock_hz + den / 2) / den;
   endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous first-word fall-through FIFO; a push into a full FIFO succeeds only alongside a pop.
module uart_rx_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         head,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    rd_ptr_q, wr_ptr_q;
   logic [AW:0]      count_q;
   logic             do_pop, do_push;

   assign empty   = (count_q == '0);
   assign full    = (count_q == (AW + 1)'(DEPTH));
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign count   = count_q;
   // Head reads as zero while empty so the output is clean after reset.
   assign head    = empty ? '0 : mem[rd_ptr_q];

   always_ff @(posedge clk) begin
      if (reset) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         if (do_push && !do_pop)      count_q <= count_q + 1'b1;
         else if (!do_push && do_pop) count_q <= count_q - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr_q] <= push_data;
   end

endmodule

// File: rtl/uart_rx_oversampled.sv
// Oversampling UART receiver with majority vote, parity/stop checks, receive FIFO and cts.
// Optional break detection is enabled by defining UART_RX_BREAK_DETECT_EN.
module uart_rx_oversampled
   import uart_pkg::*;
#(
   parameter int unsigned CLOCK_HZ   = 12_000_000,
   parameter int unsigned BAUD       = 115_200,
   parameter int unsigned OVERSAMPLE = 8,
   parameter int unsigned DATA_BITS  = 8,
   parameter int unsigned PARITY     = 0,
   parameter int unsigned STOP_BITS  = 1,
   parameter int unsigned FIFO_DEPTH = 16,
   parameter int unsigned CTS_MARGIN = 4
) (
   input  logic                          clock_12mhz,
   input  logic                          reset,
   input  logic                          rx,
   output logic                          cts,
   output logic [DATA_BITS-1:0]          rx_data,
   output logic                          rx_data_ready,
   input  logic                          rx_data_ack,
   output logic [$clog2(FIFO_DEPTH):0]   rx_fifo_count,
   output logic                          framing_error,
   output logic                          parity_error,
   output logic                          overrun,
   output logic                          break_detected
);

   localparam int unsigned DIV = uart_divisor(CLOCK_HZ, BAUD, OVERSAMPLE);
   localparam int unsigned TW  = $clog2(DIV + 1);
   localparam int unsigned SW  = $clog2(OVERSAMPLE);
   localparam int unsigned CW  = 4;

   logic rx_meta_q, rx_sync_q, rx_prev_q;
   logic [TW-1:0] tick_cnt_q;
   logic [SW-1:0] sub_q;
   logic tick, start_edge, vote_evt, vote;
   logic samp0_q, samp1_q;

   rx_state_e state_q, state_d;
   logic [CW-1:0] bit_cnt_q;
   logic [DATA_BITS-1:0] data_q;
   logic par_q, zero_q, stop_bad_q;
   logic last_data, last_stop;

   logic frame_end, stop_bad, par_bad, brk_hit, push_d, fe_d, pe_d;
   logic push_q, fe_q, pe_q, brk_q, overrun_q, cts_q;

   logic fifo_full, fifo_empty;

   always_ff @(posedge clock_12mhz) begin
      if (reset) begin
         rx_meta_q <= 1'b1;
         rx_sync_q <= 1'b1;
         rx_prev_q <= 1'b1;
      end else begin
         rx_meta_q <= rx;
         rx_sync_q <= rx_meta_q;
         rx_prev_q <= rx_sync_q;
      end
   end

   assign start_edge = (state_q == StIdle) & rx_prev_q & ~rx_sync_q;
   assign tick       = (tick_cnt_q == TW'(DIV - 1));

   // Counters restart on the start edge so subtick 0 lines up with the bit boundary.
   always_ff @(posedge clock_12mhz) begin
      if (reset || start_edge) begin
         tick_cnt_q <= '0;
         sub_q      <= '0;
      end else if (tick) begin
         tick_cnt_q <= '0;
         sub_q      <= (sub_q == SW'(OVERSAMPLE - 1)) ? '0 : sub_q + 1'b1;
      end else begin
         tick_cnt_q <= tick_cnt_q + 1'b1;
      end
   end

   // Samples taken as the subtick becomes OVERSAMPLE/2-1, /2 and /2+1.
   always_ff @(posedge clock_12mhz) begin
      if (reset) begin
         samp0_q <= 1'b1;
         samp1_q <= 1'b1;
      end else if (tick) begin
         if (sub_q == SW'(OVERSAMPLE / 2 - 2)) samp0_q <= rx_sync_q;
         if (sub_q == SW'(OVERSAMPLE / 2 - 1)) samp1_q <= rx_sync_q;
      end
   end

   assign vote_evt  = tick & (sub_q == SW'(OVERSAMPLE / 2));
   assign vote      = (samp0_q & samp1_q) | (samp0_q & rx_sync_q) | (samp1_q & rx_sync_q);
   assign last_data = (bit_cnt_q == CW'(DATA_BITS - 1));
   assign last_stop = (bit_cnt_q == CW'(STOP_BITS - 1));

   always_ff @(posedge clock_12mhz) begin
      if (reset) state_q <= StIdle;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         StIdle:   if (start_edge) state_d = StStart;
         StStart:  if (vote_evt) state_d = vote ? StIdle : StData;
         StData:   if (vote_evt && last_data) begin
            state_d = (PARITY == PARITY_NONE) ? StStop : StParity;
         end
         StParity: if (vote_evt) state_d = StStop;
         StStop:   if (vote_evt && last_stop) state_d = brk_hit ? StBreak : StIdle;
`ifdef UART_RX_BREAK_DETECT_EN
         StBreak:  if (rx_sync_q) state_d = StIdle;
`endif
         default:  state_d = StIdle;
      endcase
   end

   always_comb begin
      frame_end = (state_q == StStop) & vote_evt & last_stop;
      stop_bad  = stop_bad_q | ~vote;
      par_bad   = 1'b0;
      if (PARITY == PARITY_ODD)  par_bad = ~(^data_q ^ par_q);
      if (PARITY == PARITY_EVEN) par_bad = ^data_q ^ par_q;
`ifdef UART_RX_BREAK_DETECT_EN
      brk_hit   = frame_end & zero_q & ~vote;
`else
      brk_hit   = 1'b0;
`endif
      push_d    = frame_end & ~stop_bad & ~par_bad;
      fe_d      = frame_end & stop_bad & ~brk_hit;
      pe_d      = frame_end & par_bad & ~brk_hit;
   end

   always_ff @(posedge clock_12mhz) begin
      if (reset) begin
         bit_cnt_q  <= '0;
         data_q     <= '0;
         par_q      <= 1'b0;
         zero_q     <= 1'b0;
         stop_bad_q <= 1'b0;
         push_q     <= 1'b0;
         fe_q       <= 1'b0;
         pe_q       <= 1'b0;
         brk_q      <= 1'b0;
         overrun_q  <= 1'b0;
         cts_q      <= 1'b0;
      end else begin
         push_q    <= push_d;
         fe_q      <= fe_d;
         pe_q      <= pe_d;
         brk_q     <= brk_hit;
         overrun_q <= push_q & fifo_full & ~(rx_data_ack & ~fifo_empty);
         cts_q     <= (FIFO_DEPTH - 32'(rx_fifo_count)) >= CTS_MARGIN;
         if (start_edge) begin
            bit_cnt_q  <= '0;
            zero_q     <= 1'b1;
            stop_bad_q <= 1'b0;
         end else if (vote_evt) begin
            zero_q <= zero_q & ~vote;
            case (state_q)
               StData: begin
                  data_q    <= {vote, data_q[DATA_BITS-1:1]};
                  bit_cnt_q <= last_data ? '0 : bit_cnt_q + 1'b1;
               end
               StParity: par_q <= vote;
               StStop: begin
                  stop_bad_q <= stop_bad;
                  bit_cnt_q  <= bit_cnt_q + 1'b1;
               end
               default: ;
            endcase
         end
      end
   end

   uart_rx_fifo #(
      .WIDTH (DATA_BITS),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clock_12mhz),
      .reset     (reset),
      .push      (push_q),
      .push_data (data_q),
      .pop       (rx_data_ack),
      .head      (rx_data),
      .count     (rx_fifo_count),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   assign rx_data_ready  = ~fifo_empty;
   assign cts            = cts_q;
   assign framing_error  = fe_q;
   assign parity_error   = pe_q;
   assign overrun        = overrun_q;
   assign break_detected = brk_q;

endmodule

// File: tb/tb_uart_rx_oversampled.sv
// Scoreboard bench for uart_rx_oversampled configured with even parity and a 4-entry FIFO.
module tb_uart_rx_oversampled;

   localparam int BIT = 104;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       rx = 1'b1;
   logic       ack = 1'b0;
   logic       cts, ready, fe, pe, ov, brk;
   logic [7:0] data;
   logic [2:0] count;

   int   n_total = 0;
   int   n_bad = 0;
   int   fe_cnt = 0, pe_cnt = 0, ov_cnt = 0, brk_cnt = 0;
   bit   auto_ack = 1'b0;
   logic [7:0] exp_q[$];

   always #5 clk = ~clk;

   uart_rx_oversampled #(
      .PARITY     (2),
      .FIFO_DEPTH (4),
      .CTS_MARGIN (2)
   ) dut (
      .clock_12mhz    (clk),
      .reset          (reset),
      .rx             (rx),
      .cts            (cts),
      .rx_data        (data),
      .rx_data_ready  (ready),
      .rx_data_ack    (ack),
      .rx_fifo_count  (count),
      .framing_error  (fe),
      .parity_error   (pe),
      .overrun        (ov),
      .break_detected (brk)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: pulse counters plus scoreboard pop whenever a word is offered and acking is on.
   always @(negedge clk) begin
      if (reset) begin
         ack = 1'b0;
      end else begin
         fe_cnt  += int'(fe);
         pe_cnt  += int'(pe);
         ov_cnt  += int'(ov);
         brk_cnt += int'(brk);
         if (ready && auto_ack) begin
            if (exp_q.size() == 0) begin
               n_total++;
               n_bad++;
               $display("FAIL unexpected_word: got %0h expected none", data);
            end else begin
               check("rx_data", {24'd0, data}, {24'd0, exp_q.pop_front()});
            end
            ack = 1'b1;
         end else begin
            ack = 1'b0;
         end
      end
   end

   task automatic drive_bit(input logic b);
      rx = b;
      repeat (BIT) @(negedge clk);
   endtask

   task automatic send_frame(input logic [7:0] d, input bit par_ok, input bit stop);
      logic p;
      drive_bit(1'b0);
      for (int i = 0; i < 8; i++) drive_bit(d[i]);
      p = ^d;
      if (!par_ok) p = ~p;
      drive_bit(p);
      drive_bit(stop);
      drive_bit(1'b1);
   endtask

   task automatic wait_empty(input string name);
      int n;
      n = 0;
      while ((exp_q.size() != 0 || ready) && n < 3000) begin
         @(negedge clk);
         n++;
      end
      check(name, exp_q.size(), 0);
   endtask

   initial begin
      #5ms;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      int f0, p0, o0, b0;
      repeat (4) @(negedge clk);
      check("reset_cts", cts, 0);
      check("reset_ready", ready, 0);
      check("reset_count", count, 0);
      check("reset_data", data, 0);
      reset = 1'b0;
      @(negedge clk);
      check("cts_after_reset", cts, 1);
      repeat (20) @(negedge clk);

      // Good frame.
      auto_ack = 1'b1;
      exp_q.push_back(8'h62);
      send_frame(8'h62, 1'b1, 1'b1);
      wait_empty("t1_drain");
      check("t1_errors", fe_cnt + pe_cnt + ov_cnt + brk_cnt, 0);

      // Short glitch must be ignored.
      rx = 1'b0;
      repeat (20) @(negedge clk);
      rx = 1'b1;
      repeat (300) @(negedge clk);
      check("t2_count", count, 0);
      check("t2_errors", fe_cnt + pe_cnt, 0);
      exp_q.push_back(8'h62);
      send_frame(8'h62, 1'b1, 1'b1);
      wait_empty("t2_drain");

      // Wrong parity bit.
      f0 = fe_cnt; p0 = pe_cnt;
      send_frame(8'h62, 1'b0, 1'b1);
      repeat (20) @(negedge clk);
      check("t3_parity_pulse", pe_cnt - p0, 1);
      check("t3_no_framing", fe_cnt - f0, 0);
      check("t3_count", count, 0);
      exp_q.push_back(8'h62);
      send_frame(8'h62, 1'b1, 1'b1);
      wait_empty("t3_drain");

      // Bad stop bit.
      f0 = fe_cnt; p0 = pe_cnt;
      send_frame(8'h62, 1'b1, 1'b0);
      repeat (20) @(negedge clk);
      check("t4_framing_pulse", fe_cnt - f0, 1);
      check("t4_no_parity", pe_cnt - p0, 0);
      check("t4_count", count, 0);

      // Long low line: break if enabled, otherwise a framing error (parity of zeros is correct).
      f0 = fe_cnt; b0 = brk_cnt;
      rx = 1'b0;
      repeat (12 * BIT) @(negedge clk);
      rx = 1'b1;
      repeat (2 * BIT) @(negedge clk);
`ifdef UART_RX_BREAK_DETECT_EN
      check("t4_break", brk_cnt - b0, 1);
      check("t4_break_no_fe", fe_cnt - f0, 0);
`else
      check("t4_break", brk_cnt - b0, 0);
      check("t4_break_fe", fe_cnt - f0, 1);
`endif
      check("t4_break_count", count, 0);
      exp_q.push_back(8'h55);
      send_frame(8'h55, 1'b1, 1'b1);
      wait_empty("t4_drain");

      // Fill the FIFO without acking.
      auto_ack = 1'b0;
      repeat (4) @(negedge clk);
      o0 = ov_cnt;
      for (int i = 1; i <= 5; i++) begin
         send_frame(8'(i), 1'b1, 1'b1);
         check($sformatf("t5_count_%0d", i), count, (i > 4) ? 4 : i);
         check($sformatf("t5_cts_%0d", i), cts, (i <= 2) ? 1 : 0);
         if (i == 4) check("t5_no_overrun_yet", ov_cnt - o0, 0);
      end
      check("t5_overrun", ov_cnt - o0, 1);
      for (int i = 1; i <= 4; i++) exp_q.push_back(8'(i));
      auto_ack = 1'b1;
      wait_empty("t5_drain");
      repeat (2) @(negedge clk);
      check("t5_cts_back", cts, 1);
      check("t5_count_end", count, 0);

      // Reset during a frame with a word already held.
      auto_ack = 1'b0;
      send_frame(8'h3C, 1'b1, 1'b1);
      check("t6_held", count, 1);
      f0 = fe_cnt; p0 = pe_cnt; o0 = ov_cnt;
      drive_bit(1'b0);
      drive_bit(1'b0);
      drive_bit(1'b1);
      drive_bit(1'b0);
      reset = 1'b1;
      @(negedge clk);
      check("t6_rst_outputs", {cts, ready, count, data, fe, pe, ov, brk}, 0);
      @(negedge clk);
      rx = 1'b1;
      reset = 1'b0;
      repeat (12 * BIT) @(negedge clk);
      check("t6_count", count, 0);
      check("t6_ready", ready, 0);
      check("t6_no_errors", (fe_cnt - f0) + (pe_cnt - p0) + (ov_cnt - o0), 0);
      auto_ack = 1'b1;
      exp_q.push_back(8'hA5);
      send_frame(8'hA5, 1'b1, 1'b1);
      wait_empty("t6_drain");

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
